// File: rtl/switch_sequencer.sv
// switch_sequencer: break-before-make changeover sequencer for a two-switch pair
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset, released synchronously by the source
//   cmd_valid  select command present
//   cmd_sel    00 off, 01 side A, 10 side B, 11 illegal (treated as off, flags err_sel)
//   cmd_ready  command accepted on this edge when cmd_valid is also high
//   ctl_a      registered control level for switch A
//   ctl_b      registered control level for switch B
//   state      IDLE=00, ON_A=01, ON_B=10, DEAD=11
//   err_sel    sticky illegal-select flag, cleared only by reset
module switch_sequencer #(
  parameter int DEAD_CYCLES   = 4,
  parameter int MIN_ON_CYCLES = 16,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_sel,
  output logic       cmd_ready,
  output logic       ctl_a,
  output logic       ctl_b,
  output logic [1:0] state,
  output logic       err_sel
);
  typedef enum logic [1:0] {IDLE = 2'b00, ON_A = 2'b01, ON_B = 2'b10, DEAD = 2'b11} state_e;
  localparam logic [CNT_W-1:0] ON_LOAD   = CNT_W'(MIN_ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYCLES - 1);
  state_e           state_q, state_d, target_q, target_d, dec;
  logic [CNT_W-1:0] on_cnt_q, on_cnt_d, dead_cnt_q, dead_cnt_d;
  logic             ctl_a_q, ctl_a_d, ctl_b_q, ctl_b_d, err_q, err_d, accept;
  // off and the illegal code both decode to IDLE, so a release always targets IDLE
  assign dec       = (cmd_sel == 2'b01) ? ON_A : (cmd_sel == 2'b10) ? ON_B : IDLE;
  assign cmd_ready = (state_q == IDLE) || ((state_q != DEAD) && (on_cnt_q == '0));
  assign accept    = cmd_valid && cmd_ready;
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    on_cnt_d   = on_cnt_q;
    dead_cnt_d = dead_cnt_q;
    ctl_a_d    = ctl_a_q;
    ctl_b_d    = ctl_b_q;
    err_d      = err_q | (accept && cmd_sel == 2'b11);
    case (state_q)
      IDLE: if (accept && dec != IDLE) begin
        state_d  = dec;
        ctl_a_d  = dec == ON_A;
        ctl_b_d  = dec == ON_B;
        on_cnt_d = ON_LOAD;
      end
      ON_A, ON_B: begin
        on_cnt_d = (on_cnt_q == '0) ? '0 : on_cnt_q - 1'b1;
        // same-side command is a no-op; anything else releases through DEAD
        if (accept && dec != state_q) begin
          state_d    = DEAD;
          target_d   = dec;
          dead_cnt_d = DEAD_LOAD;
          ctl_a_d    = 1'b0;
          ctl_b_d    = 1'b0;
        end
      end
      default: begin
        ctl_a_d = 1'b0;
        ctl_b_d = 1'b0;
        if (dead_cnt_q == '0) begin
          state_d  = target_q;
          ctl_a_d  = target_q == ON_A;
          ctl_b_d  = target_q == ON_B;
          on_cnt_d = (target_q == IDLE) ? '0 : ON_LOAD;
          target_d = IDLE;
        end else begin
          dead_cnt_d = dead_cnt_q - 1'b1;
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      target_q   <= IDLE;
      on_cnt_q   <= '0;
      dead_cnt_q <= '0;
      ctl_a_q    <= 1'b0;
      ctl_b_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      on_cnt_q   <= on_cnt_d;
      dead_cnt_q <= dead_cnt_d;
      ctl_a_q    <= ctl_a_d;
      ctl_b_q    <= ctl_b_d;
      err_q      <= err_d;
    end
  end
  assign ctl_a   = ctl_a_q;
  assign ctl_b   = ctl_b_q;
  assign state   = state_q;
  assign err_sel = err_q;
endmodule

// File: tb/tb_switch_sequencer.sv
// tb_switch_sequencer: directed timing checks on the default build, randomized stream on a DEAD=1/MIN=1 build
module tb_switch_sequencer;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       v0 = 1'b0, v1 = 1'b0;
  logic [1:0] s0 = 2'b00, s1 = 2'b00;
  logic       rdy0, a0, b0, err0, rdy1, a1, b1, err1;
  logic [1:0] st0, st1;
  int         checks = 0, errors = 0;
  always #5 clk = ~clk;
  switch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(v0), .cmd_sel(s0), .cmd_ready(rdy0),
    .ctl_a(a0), .ctl_b(b0), .state(st0), .err_sel(err0)
  );
  switch_sequencer #(.DEAD_CYCLES(1), .MIN_ON_CYCLES(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(v1), .cmd_sel(s1), .cmd_ready(rdy1),
    .ctl_a(a1), .ctl_b(b1), .state(st1), .err_sel(err1)
  );
  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic send0(input logic [1:0] sel);
    v0 = 1'b1;
    s0 = sel;
    step();
    v0 = 1'b0;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({a0, b0, st0, rdy0, err0} !== 6'b000010) begin
      errors++;
      $display("FAIL reset_hold got a,b,st,rdy,err=%b want 000010", {a0, b0, st0, rdy0, err0});
    end
    rst_n = 1'b1;
    step();
    checks++;
    if ({a0, b0, st0, rdy0, err0} !== 6'b000010) begin
      errors++;
      $display("FAIL reset_release got %b want 000010", {a0, b0, st0, rdy0, err0});
    end
    send0(2'b01);
    step();
    step();
    checks++;
    if ({a0, b0, st0} !== 4'b1001) begin
      errors++;
      $display("FAIL pre_reset_on_a got a,b,st=%b want 1001", {a0, b0, st0});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({a0, b0, st0} !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset got a,b,st=%b want 0000", {a0, b0, st0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if ({a0, b0, st0, rdy0, err0} !== 6'b000010) begin
      errors++;
      $display("FAIL after_mid_reset got %b want 000010", {a0, b0, st0, rdy0, err0});
    end
  endtask
  task automatic test_close_a;
    send0(2'b01);
    for (int c = 1; c <= 16; c++) begin
      checks++;
      if ({a0, b0, st0, rdy0} !== {1'b1, 1'b0, 2'b01, c == 16}) begin
        errors++;
        $display("FAIL close_a cycle %0d got a,b,st,rdy=%b want %b", c, {a0, b0, st0, rdy0}, {1'b1, 1'b0, 2'b01, c == 16});
      end
      if (c < 16) step();
    end
  endtask
  task automatic test_changeover;
    send0(2'b10);
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if ({a0, b0, st0, rdy0} !== 5'b00110) begin
        errors++;
        $display("FAIL changeover_dead cycle k+%0d got a,b,st,rdy=%b want 00110", c, {a0, b0, st0, rdy0});
      end
      step();
    end
    for (int c = 5; c <= 20; c++) begin
      checks++;
      if ({a0, b0, st0, rdy0} !== {1'b0, 1'b1, 2'b10, c == 20}) begin
        errors++;
        $display("FAIL changeover_on_b cycle k+%0d got %b want %b", c, {a0, b0, st0, rdy0}, {1'b0, 1'b1, 2'b10, c == 20});
      end
      if (c < 20) step();
    end
  endtask
  task automatic test_release_noop;
    send0(2'b10);
    checks++;
    if ({a0, b0, st0, rdy0} !== 5'b01101) begin
      errors++;
      $display("FAIL noop_same_side got a,b,st,rdy=%b want 01101", {a0, b0, st0, rdy0});
    end
    send0(2'b00);
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if ({a0, b0, st0, rdy0} !== 5'b00110) begin
        errors++;
        $display("FAIL release_dead cycle %0d got %b want 00110", c, {a0, b0, st0, rdy0});
      end
      step();
    end
    checks++;
    if ({a0, b0, st0, rdy0} !== 5'b00001) begin
      errors++;
      $display("FAIL release_idle got a,b,st,rdy=%b want 00001", {a0, b0, st0, rdy0});
    end
  endtask
  task automatic test_illegal;
    send0(2'b01);
    repeat (15) step();
    checks++;
    if ({a0, b0, st0, rdy0, err0} !== 6'b100110) begin
      errors++;
      $display("FAIL illegal_pre got a,b,st,rdy,err=%b want 100110", {a0, b0, st0, rdy0, err0});
    end
    send0(2'b11);
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if ({a0, b0, st0, rdy0, err0} !== 6'b001101) begin
        errors++;
        $display("FAIL illegal_dead cycle %0d got %b want 001101", c, {a0, b0, st0, rdy0, err0});
      end
      step();
    end
    checks++;
    if ({a0, b0, st0, rdy0, err0} !== 6'b000011) begin
      errors++;
      $display("FAIL illegal_idle got %b want 000011", {a0, b0, st0, rdy0, err0});
    end
    send0(2'b01);
    repeat (3) step();
    checks++;
    if ({a0, err0} !== 2'b11) begin
      errors++;
      $display("FAIL err_sticky got a,err=%b want 11", {a0, err0});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a0, err0} !== 2'b00) begin
      errors++;
      $display("FAIL err_reset got a,err=%b want 00", {a0, err0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask
  task automatic test_random_stream;
    int   e = 0, side = 0, tgt = 0, rise = -1, ready_from = 0, dec, exp_st;
    int   macc = 0, dacc = 0, mrise = 0, drise = 0;
    logic merr = 1'b0, pa = 1'b0, pb = 1'b0, acc;
    for (int i = 0; i < 3000; i++) begin
      exp_st = (rise >= 0) ? 3 : side;
      checks++;
      if ({a1, b1, st1, rdy1, err1} !== {side == 1, side == 2, 2'(exp_st), e >= ready_from, merr}) begin
        errors++;
        $display("FAIL stream edge %0d got a,b,st,rdy,err=%b want %b", e, {a1, b1, st1, rdy1, err1},
                 {side == 1, side == 2, 2'(exp_st), e >= ready_from, merr});
      end
      checks++;
      if (a1 && b1) begin
        errors++;
        $display("FAIL stream_exclusive edge %0d got a,b=11 want not both high", e);
      end
      checks++;
      if ((pa && b1) || (pb && a1)) begin
        errors++;
        $display("FAIL stream_no_dead edge %0d got prev a,b=%b now a,b=%b want an all-low cycle", e, {pa, pb}, {a1, b1});
      end
      if ((a1 && !pa) || (b1 && !pb)) drise++;
      pa = a1;
      pb = b1;
      v1 = $urandom_range(0, 2) != 0;
      s1 = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      acc = v1 && (e >= ready_from);
      if (v1 && rdy1) dacc++;
      @(posedge clk);
      if (rise == e) begin
        side = tgt;
        rise = -1;
        if (tgt != 0) mrise++;
      end
      if (acc) begin
        macc++;
        dec = (s1 == 2'b01) ? 1 : (s1 == 2'b10) ? 2 : 0;
        if (s1 == 2'b11) merr = 1'b1;
        if (side == 0) begin
          if (dec != 0) begin
            side = dec;
            ready_from = e + 1;
            mrise++;
          end
        end else if (dec != side) begin
          side = 0;
          tgt = dec;
          rise = e + 1;
          ready_from = e + 2;
        end
      end
      e++;
      @(negedge clk);
    end
    v1 = 1'b0;
    if ((a1 && !pa) || (b1 && !pb)) drise++;
    checks++;
    if (dacc !== macc) begin
      errors++;
      $display("FAIL stream_accept_count got %0d want %0d", dacc, macc);
    end
    checks++;
    if (drise !== mrise) begin
      errors++;
      $display("FAIL stream_closure_count got %0d want %0d", drise, mrise);
    end
  endtask
  initial begin
    test_reset();
    test_close_a();
    test_changeover();
    test_release_noop();
    test_illegal();
    test_random_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
